cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus arbiter sitting directly downstream of the ALU reservation stations and other result producers. It collects per-source result requests, grants at most one source per cycle, and drives the registered CDB broadcast (valid, tag, data) that every reservation station snoops for operand wake-up. The grant is returned to each producer as its `accepted` strobe, so a producer holds its request and data until accepted.

## Interface
- `NUM_SRC`, 4: number of result producers (2..8).
- `DATA_W`, 4: result width.
- `TAG_W`, 4: CDB tag width; must satisfy `TAG_BASE + NUM_SRC - 1 < 2**TAG_W`.
- `TAG_BASE`, 1: tag of source 0; source i broadcasts tag `TAG_BASE + i`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `src_req`  in  NUM_SRC  per-source result request (level, held until accepted).
- `src_data`  in  NUM_SRC*DATA_W  result of source i in bits [i*DATA_W +: DATA_W].
- `flush`  in  1  squash: no grant this cycle, pending broadcast cancelled.
- `src_accepted`  out  NUM_SRC  one-hot (or zero) grant, combinational, same cycle as request.
- `cdb_valid`  out  1  registered broadcast valid.
- `cdb_tag`  out  TAG_W  registered broadcast tag.
- `cdb_data`  out  DATA_W  registered broadcast data.

## Operation
- Each cycle, grant = arbitration over `src_req` (policy per Configuration); `src_accepted` = grant, forced 0 while `rst_n`=0 or `flush`=1.
- On the edge ending a cycle with a grant to source g: `cdb_valid`<=1, `cdb_tag`<=TAG_BASE+g, `cdb_data`<=src_data slice g.
- Cycle without grant: `cdb_valid`<=0; `cdb_tag`/`cdb_data` hold previous values (don't-care when invalid, but must not toggle).
- Producer contract: request and data stable until the cycle `src_accepted` is high; producer deasserts request on the following edge. Arbiter does not store requests.
- Round-robin pointer `rr_ptr` (width clog2(NUM_SRC)): search starts at `rr_ptr`, wraps past NUM_SRC-1 to 0; after a grant to g, `rr_ptr`<=g+1 mod NUM_SRC; no grant -> pointer holds.
- `flush`: no grant, `cdb_valid`<=0, pointer holds.
- Reset: `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0, `rr_ptr`=0, `src_accepted`=0. Reset mid-broadcast drops the broadcast; no partial state survives.

## Timing
- Request-to-grant: 0 cycles (combinational). Grant-to-broadcast: 1 cycle. Throughput: one result per cycle, back-to-back broadcasts allowed.
- `src_accepted` depends only on `src_req`, `flush`, `rst_n` and registered pointer; no path from `src_data`.
- A producer seeing its own tag on the CDB the cycle after acceptance must not re-request in that cycle.
- All sources requesting continuously: each granted exactly once per NUM_SRC cycles (round-robin mode).

## Configuration
- `CDB_ARB_FIXED_PRIO_EN`: defined -> fixed priority, lowest index wins, `rr_ptr` removed; not defined (default) -> round-robin as above. Ports and latency identical in both builds.

## Structure
- Package `cdb_pkg`: `TAG_W`, `DATA_W` defaults, `TAG_NONE` (=0, never broadcast), shared by reservation stations and arbiter.
- Sub-module `rr_grant`: combinational one-hot grant from request vector and start pointer (pointer tied to 0 under `CDB_ARB_FIXED_PRIO_EN`). Top holds pointer and output registers.

## Test plan
- Reset: hold `rst_n`=0 with all `src_req`=1 -> `src_accepted`=0, `cdb_valid`=0, tag/data 0; release -> source 0 accepted first cycle, next cycle `cdb_tag`=1.
- Single request: src 2 requests with data 0xA -> `src_accepted`=0b0100 same cycle; next cycle `cdb_valid`=1, `cdb_tag`=3, `cdb_data`=0xA; one cycle later `cdb_valid`=0.
- Fairness: all four request continuously (data i+5) -> grant order 0,1,2,3,0 and broadcasts tags 1,2,3,4,1 back-to-back, `cdb_valid` held 1.
- Wrap: `rr_ptr`=3 after grant to 2, requests on 0 and 3 -> grant 3 then 0.
- Flush: requests on 1 and 2 with `flush`=1 -> `src_accepted`=0, next `cdb_valid`=0, pointer unchanged; flush released -> grant resumes at prior pointer.
- Fixed-priority build: requests on 1 and 3 held for 3 cycles -> source 1 granted every cycle, source 3 never.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB definitions used by the reservation stations and the CDB arbiter.
package cdb_pkg;
    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 4;
    // Tag value that is never broadcast; also the tag register's reset value.
    localparam logic [CDB_TAG_W-1:0] TAG_NONE = '0;
endpackage

// File: rtl/rr_grant.sv
// Combinational one-hot grant: first requester found scanning upward from ptr,
// wrapping past N-1 to 0. A pointer tied to 0 gives fixed lowest-index priority.
module rr_grant #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one grant per cycle, registered CDB broadcast.
// Define CDB_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no rr pointer).
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int DATA_W   = CDB_DATA_W,
    parameter int TAG_W    = CDB_TAG_W,
    parameter int TAG_BASE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      flush,
    output logic [NUM_SRC-1:0]        src_accepted,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
);
    localparam int PTR_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] gnt_raw;
    logic [PTR_W-1:0]   start_ptr;
    logic [PTR_W-1:0]   gidx;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign start_ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    assign start_ptr = rr_ptr_q;
`endif

    rr_grant #(.N(NUM_SRC), .PW(PTR_W)) u_grant (
        .req (src_req),
        .ptr (start_ptr),
        .gnt (gnt_raw)
    );

    // Grant path sees only req/flush/reset/pointer, never src_data.
    assign src_accepted = (rst_n && !flush) ? gnt_raw : '0;

    always_comb begin
        gidx        = '0;
        cdb_valid_d = |src_accepted;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_accepted[i]) begin
                gidx       = PTR_W'(i);
                cdb_data_d = src_data[i*DATA_W +: DATA_W];
            end
        end
        if (cdb_valid_d) cdb_tag_d = TAG_W'(TAG_BASE) + TAG_W'(gidx);
    end

`ifndef CDB_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (cdb_valid_d) rr_ptr_d = (gidx == PTR_W'(NUM_SRC-1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_W'(TAG_NONE);
            cdb_data_q  <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus randomized producers
// obeying the hold-until-accepted contract, checked against a behavioural model.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int TW = 4;
    localparam int TB = 1;

    typedef struct {
        logic [N-1:0]  acc;
        logic          v;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_req;
    logic [N*DW-1:0] src_data;
    logic            flush;
    logic [N-1:0]    src_accepted;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    // Model state: what the CDB registers and pointer should hold right now.
    int            m_ptr;
    logic          m_v;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    logic [N-1:0]  last_acc;

    cdb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .TAG_W(TW), .TAG_BASE(TB)) dut (
        .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data),
        .flush(flush), .src_accepted(src_accepted), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    // Apply one cycle of inputs, queue the expected view of that cycle, advance the model.
    task automatic cycle(input logic rst, input logic fl, input logic [N-1:0] req,
                         input logic [N*DW-1:0] dat);
        exp_t e;
        int   g;
        @(posedge clk);
        #1;
        rst_n = rst; flush = fl; src_req = req; src_data = dat;
`ifdef CDB_ARB_FIXED_PRIO_EN
        g = pick(req, 0);
`else
        g = pick(req, m_ptr);
`endif
        if (!rst || fl) g = -1;
        e.acc = '0;
        if (g >= 0) e.acc[g] = 1'b1;
        e.v = m_v; e.tag = m_tag; e.data = m_data;
        q.push_back(e);
        last_acc = e.acc;
        if (!rst) begin
            m_v = 1'b0; m_tag = '0; m_data = '0; m_ptr = 0;
        end else if (g >= 0) begin
            m_v = 1'b1;
            m_tag = TW'(TB + g);
            m_data = dat[g*DW +: DW];
            m_ptr = (g + 1) % N;
        end else begin
            m_v = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("src_accepted", 32'(src_accepted), 32'(e.acc));
                chk("cdb_valid", 32'(cdb_valid), 32'(e.v));
                chk("cdb_tag", 32'(cdb_tag), 32'(e.tag));
                chk("cdb_data", 32'(cdb_data), 32'(e.data));
            end
        end
    end

    initial begin : stim
        logic [N-1:0]    preq;
        logic [N*DW-1:0] pdat;
        logic            fl, rs;
        logic [N*DW-1:0] ramp;
        rst_n = 1'b0; flush = 1'b0; src_req = '0; src_data = '0;
        repeat (2) @(posedge clk);
        m_ptr = 0; m_v = 1'b0; m_tag = '0; m_data = '0; last_acc = '0;
        for (int i = 0; i < N; i++) ramp[i*DW +: DW] = DW'(i + 5);

        // Reset held with everyone requesting, then release.
        cycle(1'b0, 1'b0, '1, ramp);
        cycle(1'b0, 1'b0, '1, ramp);
        cycle(1'b1, 1'b0, 4'b0001, ramp);
        cycle(1'b1, 1'b0, '0, ramp);
        // Single request from source 2.
        cycle(1'b1, 1'b0, 4'b0100, {4'h0, 4'hA, 4'h0, 4'h0});
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, '0, '0);
        // All request continuously: rotation and back-to-back broadcasts.
        repeat (6) cycle(1'b1, 1'b0, '1, ramp);
        // Wrap: grant 2 leaves pointer at 3, then requests on 0 and 3.
        cycle(1'b1, 1'b0, 4'b0100, ramp);
        cycle(1'b1, 1'b0, 4'b1001, ramp);
        cycle(1'b1, 1'b0, 4'b0001, ramp);
        // Flush with requests on 1 and 2, then release.
        cycle(1'b1, 1'b1, 4'b0110, ramp);
        cycle(1'b1, 1'b1, 4'b0110, ramp);
        cycle(1'b1, 1'b0, 4'b0110, ramp);
        cycle(1'b1, 1'b0, 4'b0100, ramp);
        // Fixed-priority style pattern: 1 and 3 held.
        repeat (3) cycle(1'b1, 1'b0, 4'b1010, ramp);
        cycle(1'b1, 1'b0, '0, ramp);

        // Random producers: hold req/data until accepted, drop for the following cycle.
        preq = '0; pdat = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_acc[i]) preq[i] = 1'b0;
                else if (!preq[i] && ($urandom_range(0, 2) != 0)) begin
                    preq[i] = 1'b1;
                    pdat[i*DW +: DW] = DW'($urandom);
                end
            end
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 39) != 0);
            cycle(rs, fl, preq, pdat);
        end
        cycle(1'b1, 1'b0, '0, '0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
